// File: rtl/cgra_tcdm_pkg.sv
// Shared types and default widths for the CGRA data-memory to TCDM port bridge.
package cgra_tcdm_pkg;

  localparam int unsigned DefDataWidth      = 64;
  localparam int unsigned DefTcdmAddrWidth  = 48;
  localparam int unsigned DefCgraAddrWidth  = 6;
  localparam int unsigned DefPayloadWidth   = 16;
  localparam int unsigned DefMaxOutstanding = 4;

  typedef struct packed {
    logic [DefPayloadWidth-1:0] payload;
    logic                       predicate;
    logic                       bypass;
  } cgra_data_t;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    REQ  = 1'b1
  } issue_state_e;

  localparam logic GrantWr = 1'b0;
  localparam logic GrantRd = 1'b1;

endpackage

// File: rtl/cgra_rsp_fifo.sv
// Read-response FIFO; push and pop may happen in the same cycle.
module cgra_rsp_fifo #(
  parameter int unsigned Width = 16,
  parameter int unsigned Depth = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [Width-1:0]         data_i,
  input  logic                     pop_i,
  output logic [Width-1:0]         data_o,
  output logic                     empty_o,
  output logic                     full_o,
  output logic [$clog2(Depth):0]   count_o
);

  localparam int unsigned PtrWidth = $clog2(Depth);
  localparam int unsigned CntWidth = PtrWidth + 1;

  logic [Width-1:0]    mem_q [Depth];
  logic [Width-1:0]    mem_d [Depth];
  logic [PtrWidth-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CntWidth-1:0] count_q, count_d;
  logic                do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CntWidth'(Depth));
  assign count_o = count_q;
  assign data_o  = mem_q[rptr_q];
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  // Next-state storage, pointers and occupancy
  always_comb begin
    mem_d   = mem_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (do_push) begin
      mem_d[wptr_q] = data_i;
      wptr_d        = wptr_q + PtrWidth'(1);
    end else begin
      wptr_d = wptr_q;
    end
    if (do_pop) begin
      rptr_d = rptr_q + PtrWidth'(1);
    end else begin
      rptr_d = rptr_q;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CntWidth'(1);
      2'b01:   count_d = count_q - CntWidth'(1);
      default: count_d = count_q;
    endcase
  end

  // State registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/cgra_tcdm_port_bridge_chk.sv
// Protocol checks for the bridge: no response without an outstanding read, no push into a full FIFO.
module cgra_tcdm_port_bridge_chk (
  input logic clk_i,
  input logic rst_i,
  input logic rsp_valid_i,
  input logic inflight_zero_i,
  input logic fifo_full_i
);

  rsp_without_read: assert property (@(posedge clk_i) disable iff (rst_i)
    !(rsp_valid_i && inflight_zero_i));

  push_while_full: assert property (@(posedge clk_i) disable iff (rst_i)
    !(rsp_valid_i && fifo_full_i));

endmodule

// File: rtl/cgra_tcdm_port_bridge.sv
// CGRA en/rdy data-memory port to SNAX TCDM port bridge with credit-limited read buffering.
// Optional performance counters are enabled with CGRA_TCDM_BRIDGE_PERF_EN.
module cgra_tcdm_port_bridge
  import cgra_tcdm_pkg::*;
#(
  parameter int unsigned DataWidth      = DefDataWidth,
  parameter int unsigned TCDMAddrWidth  = DefTcdmAddrWidth,
  parameter int unsigned CgraAddrWidth  = DefCgraAddrWidth,
  parameter int unsigned PayloadWidth   = DefPayloadWidth,
  parameter logic [TCDMAddrWidth-1:0] BaseAddr = '0,
  parameter int unsigned MaxOutstanding = DefMaxOutstanding
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      waddr_en_i,
  input  logic [CgraAddrWidth-1:0]  waddr_msg_i,
  output logic                      waddr_rdy_o,
  input  logic                      wdata_en_i,
  input  logic [PayloadWidth+1:0]   wdata_msg_i,
  output logic                      wdata_rdy_o,
  input  logic                      raddr_en_i,
  input  logic [CgraAddrWidth-1:0]  raddr_msg_i,
  output logic                      raddr_rdy_o,
  output logic                      rdata_en_o,
  output logic [PayloadWidth+1:0]   rdata_msg_o,
  input  logic                      rdata_rdy_i,
  output logic                      tcdm_req_write_o,
  output logic [TCDMAddrWidth-1:0]  tcdm_req_addr_o,
  output logic [DataWidth-1:0]      tcdm_req_data_o,
  output logic [DataWidth/8-1:0]    tcdm_req_strb_o,
  output logic                      tcdm_req_q_valid_o,
  input  logic                      tcdm_rsp_q_ready_i,
  input  logic                      tcdm_rsp_p_valid_i,
  input  logic [DataWidth-1:0]      tcdm_rsp_data_i,
  output logic                      busy_o
`ifdef CGRA_TCDM_BRIDGE_PERF_EN
  ,
  output logic [31:0]               perf_wr_cnt_o,
  output logic [31:0]               perf_rd_cnt_o,
  output logic [31:0]               perf_stall_cnt_o
`endif
);

  localparam int unsigned MsgWidth   = PayloadWidth + 2;
  localparam int unsigned StrbWidth  = DataWidth / 8;
  localparam int unsigned OffsetBits = $clog2(StrbWidth);
  localparam int unsigned CntWidth   = $clog2(MaxOutstanding) + 1;

  logic                     wa_v_q, wa_v_d, wd_v_q, wd_v_d, ra_v_q, ra_v_d;
  logic [CgraAddrWidth-1:0] wa_addr_q, wa_addr_d, ra_addr_q, ra_addr_d;
  logic [MsgWidth-1:0]      wd_msg_q, wd_msg_d;
  issue_state_e             state_q, state_d;
  logic                     last_grant_q, last_grant_d;
  logic                     req_write_q, req_write_d;
  logic [TCDMAddrWidth-1:0] req_addr_q, req_addr_d;
  logic [DataWidth-1:0]     req_data_q, req_data_d;
  logic [StrbWidth-1:0]     req_strb_q, req_strb_d;
  logic [CntWidth-1:0]      inflight_q, inflight_d;

  logic                     waddr_hs, wdata_hs, raddr_hs;
  logic [CgraAddrWidth-1:0] wa_addr_eff, ra_addr_eff;
  logic [MsgWidth-1:0]      wd_msg_eff;
  logic                     wr_elig, wr_drop, rd_elig, grant_wr, grant_rd;
  logic                     rd_hs, rsp_ok, fifo_pop, fifo_empty, fifo_full;
  logic [CntWidth-1:0]      fifo_count, credits;
  logic [PayloadWidth-1:0]  fifo_data;
  logic                     unused_bits;

  function automatic logic [TCDMAddrWidth-1:0] word_to_byte(input logic [CgraAddrWidth-1:0] word);
    return BaseAddr + (TCDMAddrWidth'(word) << OffsetBits);
  endfunction

  assign waddr_hs = waddr_en_i & ~wa_v_q;
  assign wdata_hs = wdata_en_i & ~wd_v_q;
  assign raddr_hs = raddr_en_i & ~ra_v_q;

  // Incoming beats feed the arbiter directly so a request can leave one cycle after its handshake
  assign wa_addr_eff = wa_v_q ? wa_addr_q : waddr_msg_i;
  assign wd_msg_eff  = wd_v_q ? wd_msg_q : wdata_msg_i;
  assign ra_addr_eff = ra_v_q ? ra_addr_q : raddr_msg_i;

  assign wr_elig  = (wa_v_q | waddr_hs) & (wd_v_q | wdata_hs) & wd_msg_eff[1];
  assign wr_drop  = wa_v_q & wd_v_q & ~wd_msg_q[1];
  assign credits  = CntWidth'(MaxOutstanding) - fifo_count - inflight_q;
  assign rd_elig  = (ra_v_q | raddr_hs) & (credits != '0);
  assign rd_hs    = (state_q == REQ) & ~req_write_q & tcdm_rsp_q_ready_i;
  assign rsp_ok   = tcdm_rsp_p_valid_i & (inflight_q != '0);
  assign fifo_pop = ~fifo_empty & rdata_rdy_i;

  // Issue FSM and output request register
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    req_write_d  = req_write_q;
    req_addr_d   = req_addr_q;
    req_data_d   = req_data_q;
    req_strb_d   = req_strb_q;
    grant_wr     = 1'b0;
    grant_rd     = 1'b0;
    case (state_q)
      IDLE: begin
        if (wr_elig && (!rd_elig || last_grant_q == GrantRd)) begin
          grant_wr = 1'b1;
        end else if (rd_elig) begin
          grant_rd = 1'b1;
        end else begin
          grant_wr = 1'b0;
        end
      end
      REQ: begin
        if (tcdm_rsp_q_ready_i) begin
          state_d = IDLE;
        end else begin
          state_d = REQ;
        end
      end
      default: state_d = IDLE;
    endcase
    if (grant_wr) begin
      state_d      = REQ;
      last_grant_d = GrantWr;
      req_write_d  = 1'b1;
      req_addr_d   = word_to_byte(wa_addr_eff);
      req_data_d   = DataWidth'(wd_msg_eff[MsgWidth-1:2]);
      req_strb_d   = '1;
    end else if (grant_rd) begin
      state_d      = REQ;
      last_grant_d = GrantRd;
      req_write_d  = 1'b0;
      req_addr_d   = word_to_byte(ra_addr_eff);
      req_data_d   = '0;
      req_strb_d   = '0;
    end else begin
      last_grant_d = last_grant_q;
    end
  end

  // Holding registers: a granted or predicated-off beat is consumed, otherwise a handshake fills it
  always_comb begin
    wa_v_d    = wa_v_q;
    wa_addr_d = wa_addr_q;
    wd_v_d    = wd_v_q;
    wd_msg_d  = wd_msg_q;
    ra_v_d    = ra_v_q;
    ra_addr_d = ra_addr_q;
    if (grant_wr || wr_drop) begin
      wa_v_d = 1'b0;
      wd_v_d = 1'b0;
    end else begin
      if (waddr_hs) begin
        wa_v_d    = 1'b1;
        wa_addr_d = waddr_msg_i;
      end else begin
        wa_v_d = wa_v_q;
      end
      if (wdata_hs) begin
        wd_v_d   = 1'b1;
        wd_msg_d = wdata_msg_i;
      end else begin
        wd_v_d = wd_v_q;
      end
    end
    if (grant_rd) begin
      ra_v_d = 1'b0;
    end else if (raddr_hs) begin
      ra_v_d    = 1'b1;
      ra_addr_d = raddr_msg_i;
    end else begin
      ra_v_d = ra_v_q;
    end
  end

  assign inflight_d = inflight_q + CntWidth'(rd_hs) - CntWidth'(rsp_ok);

  // Bridge state registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wa_v_q       <= 1'b0;
      wa_addr_q    <= '0;
      wd_v_q       <= 1'b0;
      wd_msg_q     <= '0;
      ra_v_q       <= 1'b0;
      ra_addr_q    <= '0;
      state_q      <= IDLE;
      last_grant_q <= GrantRd;
      req_write_q  <= 1'b0;
      req_addr_q   <= '0;
      req_data_q   <= '0;
      req_strb_q   <= '0;
      inflight_q   <= '0;
    end else begin
      wa_v_q       <= wa_v_d;
      wa_addr_q    <= wa_addr_d;
      wd_v_q       <= wd_v_d;
      wd_msg_q     <= wd_msg_d;
      ra_v_q       <= ra_v_d;
      ra_addr_q    <= ra_addr_d;
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      req_write_q  <= req_write_d;
      req_addr_q   <= req_addr_d;
      req_data_q   <= req_data_d;
      req_strb_q   <= req_strb_d;
      inflight_q   <= inflight_d;
    end
  end

  cgra_rsp_fifo #(
    .Width (PayloadWidth),
    .Depth (MaxOutstanding)
  ) u_rsp_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (rsp_ok),
    .data_i  (tcdm_rsp_data_i[PayloadWidth-1:0]),
    .pop_i   (fifo_pop),
    .data_o  (fifo_data),
    .empty_o (fifo_empty),
    .full_o  (fifo_full),
    .count_o (fifo_count)
  );

  cgra_tcdm_port_bridge_chk u_chk (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .rsp_valid_i     (tcdm_rsp_p_valid_i),
    .inflight_zero_i (inflight_q == '0),
    .fifo_full_i     (fifo_full)
  );

  assign waddr_rdy_o        = ~wa_v_q;
  assign wdata_rdy_o        = ~wd_v_q;
  assign raddr_rdy_o        = ~ra_v_q;
  assign rdata_en_o         = ~fifo_empty;
  assign rdata_msg_o        = {fifo_data, 1'b1, 1'b0};
  assign tcdm_req_write_o   = req_write_q;
  assign tcdm_req_addr_o    = req_addr_q;
  assign tcdm_req_data_o    = req_data_q;
  assign tcdm_req_strb_o    = req_strb_q;
  assign tcdm_req_q_valid_o = (state_q == REQ);
  assign busy_o = wa_v_q | wd_v_q | ra_v_q | (state_q == REQ) | (inflight_q != '0) | ~fifo_empty;

  assign unused_bits = ^{tcdm_rsp_data_i[DataWidth-1:PayloadWidth], wd_msg_eff[0]};

`ifdef CGRA_TCDM_BRIDGE_PERF_EN
  logic [31:0] perf_wr_q, perf_wr_d, perf_rd_q, perf_rd_d, perf_stall_q, perf_stall_d;

  // Saturating event counters
  always_comb begin
    perf_wr_d    = perf_wr_q;
    perf_rd_d    = perf_rd_q;
    perf_stall_d = perf_stall_q;
    if (grant_wr && perf_wr_q != 32'hFFFF_FFFF) begin
      perf_wr_d = perf_wr_q + 32'd1;
    end else begin
      perf_wr_d = perf_wr_q;
    end
    if (grant_rd && perf_rd_q != 32'hFFFF_FFFF) begin
      perf_rd_d = perf_rd_q + 32'd1;
    end else begin
      perf_rd_d = perf_rd_q;
    end
    if (state_q == REQ && !tcdm_rsp_q_ready_i && perf_stall_q != 32'hFFFF_FFFF) begin
      perf_stall_d = perf_stall_q + 32'd1;
    end else begin
      perf_stall_d = perf_stall_q;
    end
  end

  // Counter registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      perf_wr_q    <= 32'd0;
      perf_rd_q    <= 32'd0;
      perf_stall_q <= 32'd0;
    end else begin
      perf_wr_q    <= perf_wr_d;
      perf_rd_q    <= perf_rd_d;
      perf_stall_q <= perf_stall_d;
    end
  end

  assign perf_wr_cnt_o    = perf_wr_q;
  assign perf_rd_cnt_o    = perf_rd_q;
  assign perf_stall_cnt_o = perf_stall_q;
`endif

endmodule

// File: doc/cgra_tcdm_port_bridge.md
Name: cgra_tcdm_port_bridge

Overview:
- Sequential adapter between one CGRA data-memory port (PyMTL en/rdy write-address, write-data, read-address and read-data channels) and one SNAX TCDM request/response port.
- Instantiated SnaxTcdmPorts times inside the CGRA accelerator wrapper. Replaces the combinational data_mem-to-TCDM mapping.
- Pairs write address with write data, arbitrates reads against writes, holds requests stable until TCDM accepts, and buffers read responses with credit flow control, because TCDM has no p_ready.

Parameters:
- DataWidth, 64, TCDM data width (bits)
- TCDMAddrWidth, 48, TCDM byte-address width
- CgraAddrWidth, 6, CGRA word-address width
- PayloadWidth, 16, CGRAData payload width
- BaseAddr, 0, TCDM byte address of CGRA word 0
- MaxOutstanding, 4, read-response FIFO depth, which is also the maximum number of reads in flight (power of 2, at least 2)

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- waddr_en_i  in  1  write-address valid
- waddr_msg_i  in  CgraAddrWidth  write word address
- waddr_rdy_o  out  1  write-address ready
- wdata_en_i  in  1  write-data valid
- wdata_msg_i  in  PayloadWidth+2  CGRAData {payload, predicate, bypass}
- wdata_rdy_o  out  1  write-data ready
- raddr_en_i  in  1  read-address valid
- raddr_msg_i  in  CgraAddrWidth  read word address
- raddr_rdy_o  out  1  read-address ready
- rdata_en_o  out  1  read-data valid
- rdata_msg_o  out  PayloadWidth+2  read CGRAData
- rdata_rdy_i  in  1  read-data ready
- tcdm_req_write_o  out  1  request is a write
- tcdm_req_addr_o  out  TCDMAddrWidth  byte address
- tcdm_req_data_o  out  DataWidth  write data
- tcdm_req_strb_o  out  DataWidth/8  byte strobes
- tcdm_req_q_valid_o  out  1  request valid
- tcdm_rsp_q_ready_i  in  1  request accepted
- tcdm_rsp_p_valid_i  in  1  read response valid
- tcdm_rsp_data_i  in  DataWidth  read response data
- busy_o  out  1  any request held or any read in flight

Behaviour:
- Clocking and reset: single clock domain, clk_i. rst_i is synchronous and active-high; it clears every register on the next edge.
- Reset values: all *_rdy_o=1 except rdata path; rdata_en_o=0, tcdm_req_q_valid_o=0, busy_o=0, all addr/data/strb outputs=0.
- Write capture:
  - One holding register each for address (wa_v) and data (wd_v).
  - waddr_rdy_o=!wa_v and wdata_rdy_o=!wd_v, so each channel transfers on en&rdy. The two may arrive in any order or in the same cycle.
  - A write is pending when wa_v&wd_v.
- Predicated-off write: if a pending write has predicate==0, both holding registers clear on the next cycle and no TCDM request is issued.
- Read capture: holding register ra_v, with raddr_rdy_o=!ra_v.
- Issue FSM, states IDLE and REQ:
  - IDLE: if a write and a read are both pending, grant using a round-robin last_grant bit; reset value is last_grant=read, so the first conflict goes to the write.
  - A read is eligible only when credits>0.
  - On grant, load the output request register, clear the consumed holding register(s), and go to REQ.
  - REQ: tcdm_req_q_valid_o=1, and all request fields stay stable until tcdm_rsp_q_ready_i. On q_ready, return to IDLE; no back-to-back issue from REQ.
  - Minimum latency: CGRA handshake on cycle N, q_valid on N+1.
- Address: tcdm_req_addr_o = BaseAddr + (word_addr << log2(DataWidth/8)), truncated to TCDMAddrWidth. Word address 63 maps to BaseAddr+504.
- Write data: payload zero-extended to DataWidth, strb all ones.
- Credits:
  - credits = MaxOutstanding − fifo_count − inflight.
  - inflight increments when a read q handshake completes and decrements on p_valid.
  - p_valid always pushes tcdm_rsp_data_i[PayloadWidth-1:0] into the FIFO; credits guarantee it never overflows.
- Read data: rdata_en_o = FIFO not empty; rdata_msg_o = {payload, predicate=1, bypass=0}; pop on rdata_en_o&rdata_rdy_i.
- Simultaneous push and pop: occupancy is unchanged. A push while full cannot occur; assert in simulation.
- p_valid with inflight==0: protocol error; assert, and ignore the response.
- Reset mid-operation: held and in-flight requests are dropped and the FIFO is flushed. TCDM must also be in reset.
- busy_o = wa_v|wd_v|ra_v|REQ|inflight!=0|fifo non-empty.

Optional Feature:
- Macro: CGRA_TCDM_BRIDGE_PERF_EN.
- Defined:
  - Adds 32-bit saturating output counters perf_wr_cnt_o (writes issued), perf_rd_cnt_o (reads issued) and perf_stall_cnt_o (cycles in REQ with q_ready=0).
  - Counters clear on rst_i.
- Undefined: these ports and counters do not exist; behaviour is otherwise identical.

Decomposition:
- Package cgra_tcdm_pkg:
  - CGRAData typedef with PayloadWidth payload, predicate and bypass.
  - Default width constants.
  - Issue-state enum {IDLE, REQ}.
- Sub-module cgra_rsp_fifo: synchronous FIFO with depth MaxOutstanding, count output, and push/pop in the same cycle.

Test Plan:
- Address and data pairing: waddr 5, then 3 cycles later wdata {0x1234,p=1}, q_ready=1 → exactly one write: addr 0x28, data 0x...1234, strb 0xFF, written one cycle after data arrives.
- Predicate-off write: wdata {0xBEEF,p=0} with waddr 7 → no q_valid, and both rdy go high again after 1 cycle.
- Back-pressure: read addr 2 with q_ready low for 4 cycles → q_valid=1 and addr 0x10 stable for all 4 cycles; one in-flight read after the handshake.
- Credit limit: 6 reads, rdata_rdy_i=0, p_valid 2 cycles after each q → exactly 4 issued, raddr_rdy_o=0 with a read held; popping one allows the 5th.
- Arbitration: write and read both pending twice in a row → order is write, read, write, read.
- Reset: assert rst_i with the FIFO holding 2 entries and REQ active → the next cycle has rdata_en_o=0, q_valid=0, busy_o=0.
